// File: rtl/mux_select_serializer.sv
// Word-to-serial sequencer: latches a WIDTH-bit word on a valid/ready handshake and
// walks a select counter across it, presenting one bit per accepted step.
module mux_select_serializer #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last,
  output logic             busy
);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // WIDTH == 2**SEL_W, so the end index is simply the bitwise complement of the start.
  localparam logic [SEL_W-1:0] LP_START = (MSB_FIRST != 0) ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] LP_END   = ~LP_START;

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic             r_last;

  logic [SEL_W-1:0] w_sel_next;
  logic             w_done;
  logic             w_load;

  assign w_sel_next = (MSB_FIRST != 0) ? r_sel - SEL_W'(1) : r_sel + SEL_W'(1);
  assign w_done     = (r_state == ST_SHIFT) && r_last && step;
  // Ready depends on step combinationally so a new word can follow the last bit with no bubble.
  assign load_ready = !reset && ((r_state == ST_IDLE) || w_done);
  assign w_load     = load_valid && load_ready;

  // NOTE: every register here uses <= so all updates see the pre-edge values of r_sel/r_last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_sel   <= LP_START;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_SHIFT;
      r_word  <= data_in;
      r_sel   <= LP_START;
      r_valid <= 1'b1;
      r_last  <= (LP_START == LP_END);
    end else if (w_done) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if ((r_state == ST_SHIFT) && step) begin
      r_sel  <= w_sel_next;
      r_last <= (w_sel_next == LP_END);
    end
  end

  assign sel       = r_sel;
  assign ser_out   = r_word[r_sel];
  assign ser_valid = r_valid;
  assign last      = r_last;
  assign busy      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_mux_select_serializer.sv
// Scoreboard bench for mux_select_serializer: an LSB-first and an MSB-first instance,
// expected bits queued at word acceptance and compared as the DUT presents them.
module tb_mux_select_serializer;

  typedef struct packed {
    logic [3:0] sel;
    logic       b;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_ready, step = 1'b0;
  logic [15:0] data_in;
  logic [3:0]  sel;
  logic        ser_out, ser_valid, last, busy;

  logic        m_load_valid, m_load_ready, m_step;
  logic [15:0] m_data;
  logic [3:0]  m_sel;
  logic        m_ser_out, m_ser_valid, m_last, m_busy;

  exp_t q[$];
  exp_t qm[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pops = 0;
  int   m_pops = 0;
  bit   step_en = 1'b0;
  bit   stall_en = 1'b0;
  logic [3:0] stall_pat = 4'b1001;
  int   cyc = 0;

  mux_select_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .step(step), .sel(sel), .ser_out(ser_out),
    .ser_valid(ser_valid), .last(last), .busy(busy)
  );

  mux_select_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .load_valid(m_load_valid), .load_ready(m_load_ready),
    .data_in(m_data), .step(m_step), .sel(m_sel), .ser_out(m_ser_out),
    .ser_valid(m_ser_valid), .last(m_last), .busy(m_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] w, input bit msb);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.sel = msb ? 4'(15 - i) : 4'(i);
      e.b   = w[e.sel];
      e.l   = (i == 15);
      if (msb) qm.push_back(e);
      else     q.push_back(e);
    end
  endtask

  task automatic mon(input bit msb, input logic v, input logic [3:0] s, input logic o,
                     input logic l, input logic r, input logic st, input logic b);
    exp_t e;
    if (!v) return;
    if (msb ? (qm.size() == 0) : (q.size() == 0)) begin
      check(msb ? "m_unexpected_bit" : "unexpected_bit", 32'(v), 32'd0);
      return;
    end
    e = msb ? qm[0] : q[0];
    check(msb ? "m_sel" : "sel", 32'(s), 32'(e.sel));
    check(msb ? "m_ser_out" : "ser_out", 32'(o), 32'(e.b));
    check(msb ? "m_last" : "last", 32'(l), 32'(e.l));
    check(msb ? "m_load_ready" : "load_ready", 32'(r), 32'(e.l & st));
    check(msb ? "m_busy" : "busy", 32'(b), 32'd1);
    if (st) begin
      if (msb) begin void'(qm.pop_front()); m_pops++; end
      else     begin void'(q.pop_front());  pops++;   end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(1'b0, ser_valid, sel, ser_out, last, load_ready, step, busy);
      mon(1'b1, m_ser_valid, m_sel, m_ser_out, m_last, m_load_ready, m_step, m_busy);
    end
  end

  // Step generator for the LSB-first instance: continuous, or the 1,0,0,1 stall pattern.
  always @(posedge clk) begin
    #1;
    step = step_en && (!stall_en || stall_pat[cyc % 4]);
    cyc++;
  end

  // Offers n words (a, then b) with load_valid held high; each is queued when accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int n);
    logic [15:0] w;
    bit          got;
    @(posedge clk); #1;
    load_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      w       = (k == 0) ? a : b;
      data_in = w;
      got     = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (load_ready) begin
          got = 1'b1;
          push_exp(w, 1'b0);
        end else if (k > 0) begin
          check("b2b_gap", 32'(ser_valid), 32'd1);
        end
      end
      if (!got) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    data_in    = 16'hDEAD;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    check("drain", 32'(q.size()), 32'd0);
    check("idle_ser_valid", 32'(ser_valid), 32'd0);
    check("idle_load_ready", 32'(load_ready), 32'd1);
  endtask

  initial begin
    int  base;
    bit  found;
    reset        = 1'b1;
    load_valid   = 1'b0;
    data_in      = 16'h0;
    m_load_valid = 1'b0;
    m_data       = 16'h0;
    m_step       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_m_sel", 32'(m_sel), 32'd15);
    @(posedge clk); #1;
    reset   = 1'b0;
    step_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(load_ready), 32'd1);
    check("post_rst_m_ready", 32'(m_load_ready), 32'd1);

    // Single word, continuous step.
    send(16'h0001, 16'h0, 1);
    wait_idle();

    // Walking one: 16 words, 256 bits.
    base = pops;
    for (int k = 0; k < 16; k++) begin
      send(16'(1 << k), 16'h0, 1);
      wait_idle();
    end
    check("sweep_bits", 32'(pops - base), 32'd256);

    // MSB-first instance.
    @(posedge clk); #1;
    m_load_valid = 1'b1;
    m_data       = 16'h8001;
    m_step       = 1'b1;
    @(negedge clk);
    check("m_accept", 32'(m_load_ready), 32'd1);
    if (m_load_ready) push_exp(16'h8001, 1'b1);
    @(posedge clk); #1;
    m_load_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (!m_busy) found = 1'b1;
    end
    check("m_idle", 32'(found), 32'd1);
    check("m_bits", 32'(m_pops), 32'd16);
    check("m_drain", 32'(qm.size()), 32'd0);

    // Back-to-back words.
    base = pops;
    send(16'hA5A5, 16'h5A5A, 2);
    wait_idle();
    check("b2b_bits", 32'(pops - base), 32'd32);

    // Stalled stepping.
    stall_en = 1'b1;
    send(16'h00F0, 16'h0, 1);
    wait_idle();
    stall_en = 1'b0;

    // Reset in the middle of a word, with a load offered during the reset cycle.
    send(16'hFFFF, 16'h0, 1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (busy && sel == 4'd7) found = 1'b1;
    end
    check("reached_sel7", 32'(found), 32'd1);
    #1;
    reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 16'hBEEF;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_ser_valid", 32'(ser_valid), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    @(posedge clk); #1;
    reset      = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(load_ready), 32'd1);
    check("midrst_busy_after", 32'(busy), 32'd0);
    base = pops;
    send(16'h0003, 16'h0, 1);
    wait_idle();
    check("post_rst_bits", 32'(pops - base), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux_select_serializer.md
Name: mux_select_serializer

Overview:
- Upstream sequencer for the 16:1 bit-select mux stage.
- Accepts a 16-bit word over a valid/ready handshake and latches it.
- Drives a 4-bit select counter through every index, one step per accepted strobe, and presents the selected bit as a serial stream with valid/last flags.
- Contains its own word register and select mux, so it can feed downstream serial consumers directly.

Parameters:
- WIDTH, 16, word width; must equal 2**SEL_W.
- SEL_W, 4, select counter width.
- MSB_FIRST, 0, 0: index order 0 up to WIDTH-1; 1: index order WIDTH-1 down to 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  data_in holds a word to be serialized.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel word.
- step  input  1  consumer accepts the current serial bit; advance.
- sel  output  SEL_W  current select index (registered).
- ser_out  output  1  word_reg[sel], combinational from registered state.
- ser_valid  output  1  ser_out is meaningful.
- last  output  1  current bit is the final index of the word.
- busy  output  1  state == SHIFT.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; it is sampled only at the rising edge of clk.
- Reset values:
  - state=IDLE, word_reg=0, sel=0 (WIDTH-1 if MSB_FIRST).
  - ser_valid=0, last=0, busy=0, ser_out=0, load_ready=0 during the reset cycle.
  - After reset deasserts, load_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - ser_valid=0, load_ready=1, step ignored.
  - load_valid=1 at an edge captures data_in into word_reg, sets sel to the start index (0, or WIDTH-1 if MSB_FIRST), and moves to SHIFT.
- SHIFT:
  - ser_valid=1; ser_out=word_reg[sel].
  - last=1 when sel equals the end index (WIDTH-1, or 0 if MSB_FIRST).
  - step=1 and not last: sel moves by +1 (or -1 if MSB_FIRST) at the next edge.
  - step=1 and last: the word is complete.
    - If load_valid=1 in the same cycle, capture data_in, reload sel to the start index, and stay in SHIFT. This gives back-to-back words with no bubble.
    - Otherwise go to IDLE.
  - step=0: hold sel and word_reg; ser_out is stable.
- load_ready = IDLE or (SHIFT and last and step). This is combinational from step; the consumer must not make step depend on load_ready.
- load_valid in SHIFT while load_ready=0 is not accepted. The word stays pending upstream, and data_in may change freely.
- Latency:
  - Word accepted at edge N: bit 0 is valid in the cycle after edge N.
  - With step held at 1, the final bit is presented in cycle N+WIDTH and IDLE is reached at edge N+WIDTH.
  - Throughput: one bit per clk; one word per WIDTH cycles when streaming back to back.
- sel arithmetic is SEL_W bits with no wrap beyond the end index; the reload to the start index is explicit.
- Reset mid-word: the current word is discarded and all reset values apply at that edge. A load_valid sampled in the reset cycle is ignored.

Test Plan:
- Reset, then load_valid=1 with data_in=16'h0001 and step=1 continuously: sel counts 0..15; ser_out=1 only at sel=0; last=1 only at sel=15; IDLE afterwards with ser_valid=0.
- Walking-one sweep, data_in=2**k for k=0..15, each fully serialized: ser_out=1 exactly when sel==k; 16 words, 256 valid bits total.
- MSB_FIRST=1, data_in=16'h8001: sel runs 15..0; ser_out=1 at the first and last bit; last=1 at sel=0.
- Back-to-back: hold load_valid=1, with word A=16'hA5A5 then B=16'h5A5A: B is accepted on A's last step; B's bit 0 appears the next cycle with no ser_valid gap; load_ready=0 during non-last SHIFT cycles.
- Stall: toggle step 1,0,0,1 on data_in=16'h00F0: sel holds during the step=0 cycles; the bit sequence equals the continuous-step case.
- Reset asserted at sel=7 mid-word: next cycle state=IDLE, sel=0, ser_valid=0, load_ready=1 after reset drops; the next word starts at sel=0.
